registrador_paralelo_serial: RTL and testbench
==============================================

# registrador_paralelo_serial

Parallel-in, serial-out shift register: captures an N-bit word through a load/ready handshake and emits it one bit per clock on a single serial line. It is the transmit-side counterpart to the team's serial-in 4-bit shift register (deslocador). With default settings, feeding its `out` into that register's `in` leaves Q3..Q0 = D after N shifts. Supports back-to-back words with no idle gap.

## Interface
- `N`, default 4: data width, in bits; legal range ≥ 2.
- `MSB_FIRST`, default 0:
  - 0: D[0] is sent first.
  - 1: D[N-1] is sent first.
- `clock` input 1: single clock; all state updates on the rising edge.
- `reset` input 1: asynchronous, active-low. 0 forces the reset state immediately, regardless of clock.
- `D` input N: parallel word; sampled only on an accepted load.
- `load` input 1: request to capture D; accepted on a rising edge where `load && ready`.
- `ready` output 1: block can accept a load this cycle.
- `out` output 1: serial data bit; registered.
- `out_valid` output 1: `out` carries a valid bit this cycle; registered.
- `done` output 1: high during the final output cycle of a word.

## Operation
- States: IDLE and SHIFT; PARITY is added when the macro is enabled.
- Internal registers:
  - shift register `sreg` [N-1:0];
  - counter `cnt`, width $clog2(N+1);
  - parity register when enabled.
- Reset (reset=0): state=IDLE, sreg=0, cnt=0, out=0, out_valid=0, done=0. `ready`=1 as soon as reset is released.
- IDLE:
  - ready=1, out=0, out_valid=0, done=0.
  - Accepted load: capture D, out ← first bit, out_valid ← 1, cnt ← 1, state → SHIFT.
- SHIFT:
  - Each edge presents the next bit on `out` and increments cnt.
  - The bit sent in the k-th cycle after the accept edge (k=0..N-1) is D[k] (MSB_FIRST=0) or D[N-1-k] (MSB_FIRST=1).
- Last-cycle rule: `done`=1 and `ready`=1 only during the last output cycle of the word (data bit N-1, or the parity bit if enabled).
  - Accepted load in the last cycle: the new word's first bit appears at the next edge; out_valid stays 1 continuously (back-to-back).
  - No load in the last cycle: next edge → IDLE; out=0, out_valid=0, done=0.
- `load` while ready=0: ignored; D is not sampled and the transfer in progress is unaffected.
- D may change freely except at the accepting edge.
- `ready` and `done` are decoded from state/cnt only; no combinational path from `load` or `D`.

## Timing
- Latency: first bit valid on `out` in the cycle immediately after the accept edge.
- Word duration: N cycles (N+1 with parity).
- Throughput: one bit per clock. Back-to-back words have zero gap.
- `done` is a single-cycle pulse per word, coincident with the final bit.
- Reset asserted mid-word: outputs go to reset values asynchronously and the partial word is discarded. There is no resumption.
- Load and reset release on the same edge: the load is not accepted; it must be held for the following edge.

## Configuration
- Macro: `REGISTRADOR_PARALELO_SERIAL_PARIDADE_EN`.
- Defined:
  - After the N data bits, one extra cycle in state PARITY outputs even parity ^D of the captured word, with out_valid=1.
  - done and ready move to this cycle. Word length is N+1.
- Undefined: no PARITY state; word length is N; no parity logic is synthesized.

## Test plan
- Reset: reset=0 mid-simulation, asynchronous to clock → out=0, out_valid=0, done=0 immediately. After release ready=1.
- Basic LSB-first: N=4, load D=4'b1011 → out = 1,1,0,1 on the four cycles after accept. out_valid=1 throughout; done=1 on the 4th bit only; then IDLE with out=0.
- Back-to-back: load 4'b0110 then 4'b1001 during done cycle → eight contiguous valid bits 0,1,1,0,1,0,0,1 with no out_valid gap.
- Busy ignore and MSB_FIRST=1: load 4'b1100, then pulse load with D=4'b0011 during bit 1 → output 1,1,0,0 unchanged; the second load is not captured.
- Reset mid-word: reset=0 after 2 bits of 4'b1111 → out_valid drops immediately. Next load 4'b0001 sends 1,0,0,0.
- Parity (macro defined): load 4'b1011 → 1,1,0,1, then parity bit 1. done on the 5th cycle only.

Source files
------------

// File: rtl/registrador_paralelo_serial.sv
// registrador_paralelo_serial: parallel-in, serial-out shift register.
// A word on D is captured when load && ready on a rising clock edge. It is then
// sent one bit per clock on `out`, with out_valid high for each valid bit.
// MSB_FIRST selects the bit order. `done` and `ready` are high only in the final
// output cycle of a word. A new word accepted in that cycle follows the current
// one with no gap.
// Optional feature: define REGISTRADOR_PARALELO_SERIAL_PARIDADE_EN to add one
// trailing even-parity bit (^D) per word in an extra PARITY state.
//
// Handshake: `ready` depends only on registered state. A load is accepted on a
// rising edge where load && ready. D is sampled only on that edge, and a load
// while ready=0 is ignored.
module registrador_paralelo_serial #(
  parameter int N         = 4,
  parameter int MSB_FIRST = 0
) (
  input  logic         clock,
  input  logic         reset,
  input  logic [N-1:0] D,
  input  logic         load,
  output logic         ready,
  output logic         out,
  output logic         out_valid,
  output logic         done,
  output logic [1:0]   state_dbg
);

  localparam int CW = $clog2(N + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(N);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

`ifdef REGISTRADOR_PARALELO_SERIAL_PARIDADE_EN
  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, PARITY = 2'd2} state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1} state_t;
`endif

  state_t        state_q, state_d;
  logic [N-1:0]  sreg_q, sreg_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          out_q, out_d;
  logic          out_valid_q, out_valid_d;
`ifdef REGISTRADOR_PARALELO_SERIAL_PARIDADE_EN
  logic          parity_q, parity_d;
`endif

  logic last_bit;
  logic word_end;
  logic accept;

  // Decode the last-cycle condition and the handshake from registered state only.
  always_comb begin
    last_bit = (state_q == SHIFT) && (cnt_q == CNT_LAST);
`ifdef REGISTRADOR_PARALELO_SERIAL_PARIDADE_EN
    word_end = (state_q == PARITY);
`else
    word_end = last_bit;
`endif
    ready  = (state_q == IDLE) || word_end;
    accept = load && ready;
  end

  // Next-state logic: capture on accept, otherwise shift, emit parity, or go idle.
  always_comb begin
    state_d     = state_q;
    sreg_d      = sreg_q;
    cnt_d       = cnt_q;
    out_d       = 1'b0;
    out_valid_d = 1'b0;
`ifdef REGISTRADOR_PARALELO_SERIAL_PARIDADE_EN
    parity_d    = parity_q;
`endif
    if (accept) begin
      // The first bit goes straight to `out`. sreg keeps the rest, pre-shifted.
      out_d       = (MSB_FIRST != 0) ? D[N-1] : D[0];
      sreg_d      = (MSB_FIRST != 0) ? (D << 1) : (D >> 1);
      cnt_d       = CNT_ONE;
      out_valid_d = 1'b1;
      state_d     = SHIFT;
`ifdef REGISTRADOR_PARALELO_SERIAL_PARIDADE_EN
      parity_d    = ^D;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          cnt_d = '0;
        end
        SHIFT: begin
          if (!last_bit) begin
            out_d       = (MSB_FIRST != 0) ? sreg_q[N-1] : sreg_q[0];
            sreg_d      = (MSB_FIRST != 0) ? (sreg_q << 1) : (sreg_q >> 1);
            cnt_d       = cnt_q + CNT_ONE;
            out_valid_d = 1'b1;
          end else begin
`ifdef REGISTRADOR_PARALELO_SERIAL_PARIDADE_EN
            out_d       = parity_q;
            out_valid_d = 1'b1;
            state_d     = PARITY;
`else
            cnt_d       = '0;
            state_d     = IDLE;
`endif
          end
        end
`ifdef REGISTRADOR_PARALELO_SERIAL_PARIDADE_EN
        PARITY: begin
          cnt_d   = '0;
          state_d = IDLE;
        end
`endif
        default: begin
          cnt_d   = '0;
          state_d = IDLE;
        end
      endcase
    end
  end

  // State and datapath registers. An asynchronous active-low reset drops any partial word.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      sreg_q      <= '0;
      cnt_q       <= '0;
      out_q       <= 1'b0;
      out_valid_q <= 1'b0;
`ifdef REGISTRADOR_PARALELO_SERIAL_PARIDADE_EN
      parity_q    <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      sreg_q      <= sreg_d;
      cnt_q       <= cnt_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
`ifdef REGISTRADOR_PARALELO_SERIAL_PARIDADE_EN
      parity_q    <= parity_d;
`endif
    end
  end

  // Drive the outputs from the registers; done marks the final cycle of each word.
  always_comb begin
    out       = out_q;
    out_valid = out_valid_q;
    done      = word_end;
    state_dbg = state_q;
  end

endmodule

// File: tb/tb_registrador_paralelo_serial.sv
// Directed testbench for registrador_paralelo_serial (N=4).
// Two instances share clock and reset: `dut` is LSB-first and `dut_m` is MSB-first.
// With REGISTRADOR_PARALELO_SERIAL_PARIDADE_EN defined, the expected streams
// include the trailing parity bit.
module tb_registrador_paralelo_serial;

  localparam int N = 4;
`ifdef REGISTRADOR_PARALELO_SERIAL_PARIDADE_EN
  localparam int WL = N + 1;
`else
  localparam int WL = N;
`endif

  logic         clock;
  logic         reset;
  logic [N-1:0] d_l, d_m;
  logic         load_l, load_m;
  logic         ready_l, ready_m;
  logic         out_l, out_m;
  logic         ov_l, ov_m;
  logic         done_l, done_m;
  logic [1:0]   st_l, st_m;

  int checks = 0;
  int errors = 0;

  registrador_paralelo_serial #(.N(N), .MSB_FIRST(0)) dut (
    .clock(clock), .reset(reset), .D(d_l), .load(load_l), .ready(ready_l),
    .out(out_l), .out_valid(ov_l), .done(done_l), .state_dbg(st_l)
  );

  registrador_paralelo_serial #(.N(N), .MSB_FIRST(1)) dut_m (
    .clock(clock), .reset(reset), .D(d_m), .load(load_m), .ready(ready_m),
    .out(out_m), .out_valid(ov_m), .done(done_m), .state_dbg(st_m)
  );

  // Clock and reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Advance one rising edge. Inputs are driven and outputs sampled 1 ns later.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset  = 1'b0;
    load_l = 1'b0; load_m = 1'b0;
    d_l = '0; d_m = '0;
    tick(); tick();
    checks++;
    if (out_l !== 1'b0 || ov_l !== 1'b0 || done_l !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: got out=%b ov=%b done=%b expected 0 0 0", out_l, ov_l, done_l);
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if (ready_l !== 1'b1 || ready_m !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready: got %b/%b expected 1/1", ready_l, ready_m);
    end
  endtask

  task automatic test_basic_lsb();
    logic exp_q[$];
`ifdef REGISTRADOR_PARALELO_SERIAL_PARIDADE_EN
    exp_q = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
`else
    exp_q = '{1'b1, 1'b1, 1'b0, 1'b1};
`endif
    tick();
    d_l = 4'b1011; load_l = 1'b1;
    tick();
    load_l = 1'b0; d_l = 4'b0000;
    for (int k = 0; k < WL; k++) begin
      checks++;
      if (out_l !== exp_q[k] || ov_l !== 1'b1) begin
        errors++;
        $display("FAIL basic_bit%0d: got out=%b ov=%b expected out=%b ov=1", k, out_l, ov_l, exp_q[k]);
      end
      checks++;
      if (done_l !== (k == WL - 1) || ready_l !== (k == WL - 1)) begin
        errors++;
        $display("FAIL basic_done%0d: got done=%b ready=%b expected %b", k, done_l, ready_l, (k == WL - 1));
      end
      tick();
    end
    checks++;
    if (out_l !== 1'b0 || ov_l !== 1'b0 || done_l !== 1'b0 || ready_l !== 1'b1) begin
      errors++;
      $display("FAIL basic_idle: got out=%b ov=%b done=%b ready=%b expected 0 0 0 1", out_l, ov_l, done_l, ready_l);
    end
  endtask

  task automatic test_back_to_back();
    logic exp_q[$];
`ifdef REGISTRADOR_PARALELO_SERIAL_PARIDADE_EN
    exp_q = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
`else
    exp_q = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
`endif
    d_l = 4'b0110; load_l = 1'b1;
    tick();
    load_l = 1'b0;
    for (int i = 0; i < 2 * WL; i++) begin
      checks++;
      if (out_l !== exp_q[i] || ov_l !== 1'b1) begin
        errors++;
        $display("FAIL b2b_bit%0d: got out=%b ov=%b expected out=%b ov=1", i, out_l, ov_l, exp_q[i]);
      end
      checks++;
      if (done_l !== ((i % WL) == WL - 1)) begin
        errors++;
        $display("FAIL b2b_done%0d: got %b expected %b", i, done_l, ((i % WL) == WL - 1));
      end
      if (i == WL - 1) begin
        d_l = 4'b1001; load_l = 1'b1;
      end else begin
        load_l = 1'b0;
      end
      tick();
    end
    checks++;
    if (ov_l !== 1'b0 || out_l !== 1'b0) begin
      errors++;
      $display("FAIL b2b_idle: got out=%b ov=%b expected 0 0", out_l, ov_l);
    end
  endtask

  task automatic test_busy_msb();
    logic exp_q[$];
`ifdef REGISTRADOR_PARALELO_SERIAL_PARIDADE_EN
    exp_q = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
`else
    exp_q = '{1'b1, 1'b1, 1'b0, 1'b0};
`endif
    d_m = 4'b1100; load_m = 1'b1;
    tick();
    load_m = 1'b0;
    for (int k = 0; k < WL; k++) begin
      checks++;
      if (out_m !== exp_q[k] || ov_m !== 1'b1 || done_m !== (k == WL - 1)) begin
        errors++;
        $display("FAIL msb_bit%0d: got out=%b ov=%b done=%b expected out=%b ov=1 done=%b",
                 k, out_m, ov_m, done_m, exp_q[k], (k == WL - 1));
      end
      if (k == 1) begin
        checks++;
        if (ready_m !== 1'b0) begin
          errors++;
          $display("FAIL msb_busy_ready: got %b expected 0", ready_m);
        end
        d_m = 4'b0011; load_m = 1'b1;
      end else begin
        load_m = 1'b0;
      end
      tick();
    end
    for (int j = 0; j < 2; j++) begin
      checks++;
      if (ov_m !== 1'b0 || out_m !== 1'b0) begin
        errors++;
        $display("FAIL msb_ignored%0d: got out=%b ov=%b expected 0 0", j, out_m, ov_m);
      end
      tick();
    end
  endtask

  task automatic test_reset_mid_word();
    logic exp_q[$];
`ifdef REGISTRADOR_PARALELO_SERIAL_PARIDADE_EN
    exp_q = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
`else
    exp_q = '{1'b1, 1'b0, 1'b0, 1'b0};
`endif
    d_l = 4'b1111; load_l = 1'b1;
    tick();
    load_l = 1'b0;
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (out_l !== 1'b1 || ov_l !== 1'b1) begin
        errors++;
        $display("FAIL rst_pre%0d: got out=%b ov=%b expected 1 1", k, out_l, ov_l);
      end
      if (k == 0) tick();
    end
    #3 reset = 1'b0;
    #1;
    checks++;
    if (ov_l !== 1'b0 || out_l !== 1'b0 || done_l !== 1'b0) begin
      errors++;
      $display("FAIL rst_async: got out=%b ov=%b done=%b expected 0 0 0", out_l, ov_l, done_l);
    end
    #1 reset = 1'b1;
    tick();
    checks++;
    if (ov_l !== 1'b0 || ready_l !== 1'b1) begin
      errors++;
      $display("FAIL rst_discard: got ov=%b ready=%b expected 0 1", ov_l, ready_l);
    end
    d_l = 4'b0001; load_l = 1'b1;
    tick();
    load_l = 1'b0;
    for (int k = 0; k < WL; k++) begin
      checks++;
      if (out_l !== exp_q[k] || ov_l !== 1'b1 || done_l !== (k == WL - 1)) begin
        errors++;
        $display("FAIL rst_next_bit%0d: got out=%b ov=%b done=%b expected out=%b ov=1 done=%b",
                 k, out_l, ov_l, done_l, exp_q[k], (k == WL - 1));
      end
      tick();
    end
    checks++;
    if (ov_l !== 1'b0) begin
      errors++;
      $display("FAIL rst_next_idle: got ov=%b expected 0", ov_l);
    end
  endtask

  initial begin
    test_reset();
    test_basic_lsb();
    test_back_to_back();
    test_busy_msb();
    test_reset_mid_word();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
